// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters, resolve-time mispredict
// detection and saturating branch/mispredict statistics.
module branch_predictor #(
    parameter int unsigned ENTRIES = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_pc_F,
    output logic        o_pred_taken,
    output logic [31:0] o_pred_target,
    input  logic        i_upd_vld,
    input  logic [31:0] i_upd_pc,
    input  logic        i_upd_is_jump,
    input  logic        i_upd_taken,
    input  logic [31:0] i_upd_target,
    input  logic        i_upd_pred_taken,
    input  logic [31:0] i_upd_pred_target,
    output logic        o_mispred,
    output logic [31:0] o_redirect_pc,
    output logic [31:0] o_br_cnt,
    output logic [31:0] o_mispred_cnt
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = 30 - IDX_W;

    logic             r_valid  [ENTRIES];
    logic [TAG_W-1:0] r_tag    [ENTRIES];
    logic [29:0]      r_target [ENTRIES];
    logic [1:0]       r_ctr    [ENTRIES];
    logic [31:0]      r_br_cnt;
    logic [31:0]      r_mispred_cnt;

    logic [IDX_W-1:0] w_lk_idx;
    logic [TAG_W-1:0] w_lk_tag;
    logic             w_lk_hit;
    logic [IDX_W-1:0] w_up_idx;
    logic [TAG_W-1:0] w_up_tag;
    logic             w_up_hit;
    logic             w_up_taken;
    logic             w_mispred;
    logic [1:0]       w_ctr_next;

    // Fetch-side lookup reads registered table state only, so a same-cycle
    // update is not visible until the following cycle.
    assign w_lk_idx      = i_pc_F[IDX_W+1:2];
    assign w_lk_tag      = i_pc_F[31:IDX_W+2];
    assign w_lk_hit      = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    assign o_pred_taken  = w_lk_hit && r_ctr[w_lk_idx][1];
    assign o_pred_target = w_lk_hit ? {r_target[w_lk_idx], 2'b00} : i_pc_F + 32'd4;

    assign w_up_idx   = i_upd_pc[IDX_W+1:2];
    assign w_up_tag   = i_upd_pc[31:IDX_W+2];
    assign w_up_hit   = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
    assign w_up_taken = i_upd_is_jump || i_upd_taken;

    assign w_mispred     = i_upd_vld && ((i_upd_taken != i_upd_pred_taken) ||
                           (i_upd_taken && (i_upd_target != i_upd_pred_target)));
    assign o_mispred     = w_mispred;
    assign o_redirect_pc = i_upd_taken ? i_upd_target : i_upd_pc + 32'd4;

    // Counter next value: saturating train on a hit, initial strength on allocate.
    always_comb begin
        w_ctr_next = r_ctr[w_up_idx];
        if (w_up_hit) begin
            if (w_up_taken) begin
                if (r_ctr[w_up_idx] != 2'd3) w_ctr_next = r_ctr[w_up_idx] + 2'd1;
            end else begin
                if (r_ctr[w_up_idx] != 2'd0) w_ctr_next = r_ctr[w_up_idx] - 2'd1;
            end
        end else begin
            w_ctr_next = i_upd_is_jump ? 2'd3 : 2'd2;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
                r_ctr[i]   <= 2'd1;
            end
            r_br_cnt      <= 32'd0;
            r_mispred_cnt <= 32'd0;
        end else begin
            if (i_upd_vld && (w_up_hit || w_up_taken)) begin
                r_valid[w_up_idx] <= 1'b1;
                r_ctr[w_up_idx]   <= w_ctr_next;
            end
            if (i_upd_vld && (r_br_cnt != 32'hFFFF_FFFF))
                r_br_cnt <= r_br_cnt + 32'd1;
            if (w_mispred && (r_mispred_cnt != 32'hFFFF_FFFF))
                r_mispred_cnt <= r_mispred_cnt + 32'd1;
        end
    end

    // Tag/target need no reset; they are qualified by the valid bit.
    always_ff @(posedge i_clk) begin
        if (!i_reset && i_upd_vld && w_up_taken) begin
            r_tag[w_up_idx]    <= w_up_tag;
            r_target[w_up_idx] <= i_upd_target[31:2];
        end
    end

    assign o_br_cnt      = r_br_cnt;
    assign o_mispred_cnt = r_mispred_cnt;

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: vector table for lookup/resolve behaviour,
// queued count expectations, plus reset-priority and saturation sequences.
module tb_branch_predictor;

    logic        clk;
    logic        i_reset;
    logic [31:0] i_pc_F;
    logic        o_pred_taken;
    logic [31:0] o_pred_target;
    logic        i_upd_vld;
    logic [31:0] i_upd_pc;
    logic        i_upd_is_jump;
    logic        i_upd_taken;
    logic [31:0] i_upd_target;
    logic        i_upd_pred_taken;
    logic [31:0] i_upd_pred_target;
    logic        o_mispred;
    logic [31:0] o_redirect_pc;
    logic [31:0] o_br_cnt;
    logic [31:0] o_mispred_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    branch_predictor #(.ENTRIES(16)) dut (
        .i_clk             (clk),
        .i_reset           (i_reset),
        .i_pc_F            (i_pc_F),
        .o_pred_taken      (o_pred_taken),
        .o_pred_target     (o_pred_target),
        .i_upd_vld         (i_upd_vld),
        .i_upd_pc          (i_upd_pc),
        .i_upd_is_jump     (i_upd_is_jump),
        .i_upd_taken       (i_upd_taken),
        .i_upd_target      (i_upd_target),
        .i_upd_pred_taken  (i_upd_pred_taken),
        .i_upd_pred_target (i_upd_pred_target),
        .o_mispred         (o_mispred),
        .o_redirect_pc     (o_redirect_pc),
        .o_br_cnt          (o_br_cnt),
        .o_mispred_cnt     (o_mispred_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc_f;
        logic        vld;
        logic [31:0] upc;
        logic        jump;
        logic        taken;
        logic [31:0] tgt;
        logic        ptaken;
        logic [31:0] ptgt;
        logic        e_taken;
        logic [31:0] e_target;
        logic        e_mispred;
        logic [31:0] e_redirect;
    } vec_t;

    typedef struct {
        logic [31:0] br;
        logic [31:0] mp;
    } cnt_t;

    vec_t        vt [14];
    cnt_t        sb [$];
    logic [31:0] m_br;
    logic [31:0] m_mp;

    function automatic vec_t mk(input logic [31:0] pc_f, input logic vld, input logic [31:0] upc,
                                input logic jump, input logic taken, input logic [31:0] tgt,
                                input logic ptaken, input logic [31:0] ptgt, input logic e_taken,
                                input logic [31:0] e_target, input logic e_mispred,
                                input logic [31:0] e_redirect);
        vec_t v;
        v.pc_f = pc_f; v.vld = vld; v.upc = upc; v.jump = jump; v.taken = taken; v.tgt = tgt;
        v.ptaken = ptaken; v.ptgt = ptgt; v.e_taken = e_taken; v.e_target = e_target;
        v.e_mispred = e_mispred; v.e_redirect = e_redirect;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic set_upd(input logic vld, input logic [31:0] upc, input logic jump,
                           input logic taken, input logic [31:0] tgt,
                           input logic ptaken, input logic [31:0] ptgt);
        i_upd_vld = vld; i_upd_pc = upc; i_upd_is_jump = jump; i_upd_taken = taken;
        i_upd_target = tgt; i_upd_pred_taken = ptaken; i_upd_pred_target = ptgt;
    endtask

    // Drive one vector, check combinational outputs, then check queued counts.
    task automatic apply(input vec_t v, input int k);
        cnt_t c;
        @(negedge clk);
        i_pc_F = v.pc_f;
        set_upd(v.vld, v.upc, v.jump, v.taken, v.tgt, v.ptaken, v.ptgt);
        #1;
        chk($sformatf("v%0d pred_taken", k), 32'(o_pred_taken), 32'(v.e_taken));
        chk($sformatf("v%0d pred_target", k), o_pred_target, v.e_target);
        chk($sformatf("v%0d mispred", k), 32'(o_mispred), 32'(v.e_mispred));
        if (v.vld) chk($sformatf("v%0d redirect", k), o_redirect_pc, v.e_redirect);
        if (v.vld) m_br = m_br + 32'd1;
        if (v.e_mispred) m_mp = m_mp + 32'd1;
        c.br = m_br; c.mp = m_mp;
        sb.push_back(c);
        @(posedge clk);
        #1;
        c = sb.pop_front();
        chk($sformatf("v%0d br_cnt", k), o_br_cnt, c.br);
        chk($sformatf("v%0d mispred_cnt", k), o_mispred_cnt, c.mp);
    endtask

    initial begin
        vt[0]  = mk(32'h100, 0, 32'h0,  0, 0, 32'h0,   0, 32'h0,   0, 32'h104, 0, 32'h0);
        vt[1]  = mk(32'h040, 1, 32'h40, 0, 1, 32'h80,  0, 32'h44,  0, 32'h044, 1, 32'h80);
        vt[2]  = mk(32'h040, 1, 32'h40, 0, 0, 32'h0,   1, 32'h80,  1, 32'h080, 1, 32'h44);
        vt[3]  = mk(32'h040, 1, 32'h40, 0, 0, 32'h0,   0, 32'h80,  0, 32'h080, 0, 32'h44);
        vt[4]  = mk(32'h040, 0, 32'h0,  0, 0, 32'h0,   0, 32'h0,   0, 32'h080, 0, 32'h0);
        vt[5]  = mk(32'h040, 1, 32'h40, 1, 1, 32'h200, 0, 32'h44,  0, 32'h080, 1, 32'h200);
        vt[6]  = mk(32'h040, 1, 32'h80, 1, 1, 32'h300, 0, 32'h84,  0, 32'h200, 1, 32'h300);
        vt[7]  = mk(32'h040, 0, 32'h0,  0, 0, 32'h0,   0, 32'h0,   0, 32'h044, 0, 32'h0);
        vt[8]  = mk(32'h080, 0, 32'h0,  0, 0, 32'h0,   0, 32'h0,   1, 32'h300, 0, 32'h0);
        vt[9]  = mk(32'h00C, 1, 32'hC,  0, 1, 32'h400, 0, 32'h10,  0, 32'h010, 1, 32'h400);
        vt[10] = mk(32'h00C, 1, 32'hC,  0, 1, 32'h400, 1, 32'h400, 1, 32'h400, 0, 32'h400);
        vt[11] = mk(32'h00C, 1, 32'hC,  0, 1, 32'h500, 1, 32'h400, 1, 32'h400, 1, 32'h500);
        vt[12] = mk(32'h00C, 1, 32'h1C, 0, 0, 32'h0,   0, 32'h20,  1, 32'h500, 0, 32'h20);
        vt[13] = mk(32'h01C, 0, 32'h0,  0, 0, 32'h0,   0, 32'h0,   0, 32'h020, 0, 32'h0);

        i_reset = 1'b1;
        i_pc_F  = 32'h100;
        set_upd(0, 32'h0, 0, 0, 32'h0, 0, 32'h0);
        m_br = 32'd0;
        m_mp = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        i_reset = 1'b0;
        #1;
        chk("reset br_cnt", o_br_cnt, 32'd0);
        chk("reset mispred_cnt", o_mispred_cnt, 32'd0);
        chk("reset lookup taken", 32'(o_pred_taken), 32'd0);
        chk("reset lookup target", o_pred_target, 32'h104);

        for (int k = 0; k < 14; k++) apply(vt[k], k);

        // Reset wins over a concurrent update.
        @(negedge clk);
        i_reset = 1'b1;
        set_upd(1, 32'hC, 1, 1, 32'h600, 0, 32'h10);
        @(posedge clk);
        @(negedge clk);
        i_reset = 1'b0;
        set_upd(0, 32'h0, 0, 0, 32'h0, 0, 32'h0);
        i_pc_F = 32'h0C;
        #1;
        chk("rst prio taken 0C", 32'(o_pred_taken), 32'd0);
        chk("rst prio target 0C", o_pred_target, 32'h10);
        chk("rst prio br_cnt", o_br_cnt, 32'd0);
        chk("rst prio mispred_cnt", o_mispred_cnt, 32'd0);
        i_pc_F = 32'h80;
        #1;
        chk("rst prio target 80", o_pred_target, 32'h84);

        // Mispredict counter saturation from a preloaded all-ones value.
        @(negedge clk);
        force dut.r_mispred_cnt = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        release dut.r_mispred_cnt;
        #1;
        chk("sat preload", o_mispred_cnt, 32'hFFFF_FFFF);
        @(negedge clk);
        set_upd(1, 32'h100, 0, 1, 32'h180, 0, 32'h104);
        #1;
        chk("sat mispred", 32'(o_mispred), 32'd1);
        chk("sat redirect", o_redirect_pc, 32'h180);
        @(posedge clk);
        #1;
        chk("sat mispred_cnt", o_mispred_cnt, 32'hFFFF_FFFF);
        chk("sat br_cnt", o_br_cnt, 32'd1);
        @(negedge clk);
        set_upd(0, 32'h0, 0, 0, 32'h0, 0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
